// File: rtl/weight_pingpong_buf.sv
// weight_pingpong_buf: ping-pong weight line store. The write side packs RATIO
// narrow beats per lane into one wide line and fills one bank while the read
// side streams lines out of the other bank.
// Optional access checking (sticky err_flag) is built only when the macro
// WEIGHT_BUF_ACCESS_CHECK_EN is defined; otherwise err_flag is tied low.
module weight_pingpong_buf #(
  parameter int unsigned LANE_NUM      = 9,
  parameter int unsigned LANE_IN_WIDTH = 36,
  parameter int unsigned RATIO         = 4,
  parameter int unsigned DEPTH         = 256,
  parameter int unsigned ADDR_WIDTH    = 8
) (
  input  logic                                    clk,
  input  logic                                    rstn,
  input  logic [LANE_NUM*LANE_IN_WIDTH-1:0]       wr_data,
  input  logic                                    wr_valid,
  input  logic                                    wr_last,
  output logic                                    wr_ready,
  output logic                                    rd_bank_valid,
  output logic [ADDR_WIDTH:0]                     rd_lines,
  input  logic                                    rd_en,
  input  logic [ADDR_WIDTH-1:0]                   rd_addr,
  output logic [LANE_NUM*LANE_IN_WIDTH*RATIO-1:0] rd_data,
  output logic                                    rd_valid,
  input  logic                                    rd_release,
  output logic                                    err_flag
);

  localparam int unsigned LANE_OUT_W = LANE_IN_WIDTH * RATIO;
  localparam int unsigned LINE_W     = LANE_NUM * LANE_OUT_W;
  localparam int unsigned CNT_W      = ADDR_WIDTH + 1;
  localparam int unsigned BEAT_W     = (RATIO > 1) ? $clog2(RATIO) : 1;

  localparam logic [1:0] EMPTY   = 2'd0;
  localparam logic [1:0] FILLING = 2'd1;
  localparam logic [1:0] FULL    = 2'd2;

  // Per-bank state and latched line counts
  logic [1:0][1:0]       state_q, state_d;
  logic [1:0][CNT_W-1:0] lines_q, lines_d;
  logic                  wr_bank_q, wr_bank_d;
  logic                  rd_bank_q, rd_bank_d;

  // Packing state
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [CNT_W-1:0]      line_cnt_q, line_cnt_d;
  logic [LINE_W-1:0]     pack_q, pack_d;
  logic [LINE_W-1:0]     merged;

  // Registered line write (lands one cycle after the closing beat)
  logic                  lw_en_q, lw_en_d;
  logic                  lw_bank_q, lw_bank_d;
  logic [ADDR_WIDTH-1:0] lw_addr_q, lw_addr_d;
  logic [LINE_W-1:0]     lw_data_q, lw_data_d;
  logic                  cmpl_q, cmpl_d;

  // Registered outputs of the control path
  logic                  wr_ready_q, wr_ready_d;
  logic                  rd_bank_valid_q, rd_bank_valid_d;
  logic [CNT_W-1:0]      rd_lines_q, rd_lines_d;

  // Read pipeline
  logic                  rd1_v_q, rd1_oob_q;
  logic [ADDR_WIDTH:0]   rd1_addr_q;
  logic                  rd_valid_q;
  logic [LINE_W-1:0]     rd_data_q;

  logic                  accept;
  logic                  line_end;

  logic [LINE_W-1:0]     mem_q [2*DEPTH];

  assign accept   = wr_valid & wr_ready_q;
  assign line_end = wr_last | (beat_q == BEAT_W'(RATIO - 1));

  // Next-state logic: bank states, packing, fill completion and release
  always_comb begin
    state_d    = state_q;
    lines_d    = lines_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    beat_d     = beat_q;
    line_cnt_d = line_cnt_q;
    pack_d     = pack_q;
    merged     = pack_q;
    lw_en_d    = 1'b0;
    lw_bank_d  = lw_bank_q;
    lw_addr_d  = lw_addr_q;
    lw_data_d  = lw_data_q;
    cmpl_d     = 1'b0;

    for (int unsigned i = 0; i < LANE_NUM; i++) begin
      merged[i*LANE_OUT_W + int'(beat_q)*LANE_IN_WIDTH +: LANE_IN_WIDTH] =
        wr_data[i*LANE_IN_WIDTH +: LANE_IN_WIDTH];
    end

    if (accept) begin
      if (state_q[wr_bank_q] == EMPTY) state_d[wr_bank_q] = FILLING;
      if (line_end) begin
        // Close the line: unfilled sub-words stay zero because pack_q was cleared
        lw_en_d    = 1'b1;
        lw_bank_d  = wr_bank_q;
        lw_addr_d  = line_cnt_q[ADDR_WIDTH-1:0];
        lw_data_d  = merged;
        pack_d     = '0;
        beat_d     = '0;
        line_cnt_d = line_cnt_q + 1'b1;
        cmpl_d     = wr_last | (line_cnt_q == CNT_W'(DEPTH - 1));
      end else begin
        pack_d = merged;
        beat_d = beat_q + 1'b1;
      end
    end

    // Completion cycle: no beat can be accepted here since wr_ready is low
    if (cmpl_q) begin
      state_d[lw_bank_q] = FULL;
      lines_d[lw_bank_q] = line_cnt_q;
      line_cnt_d         = '0;
      wr_bank_d          = ~wr_bank_q;
    end

    // The read bank is FULL whenever release is honoured, so it never collides
    // with the bank completing above
    if (rd_release && rd_bank_valid_q) begin
      state_d[rd_bank_q] = EMPTY;
      rd_bank_d          = ~rd_bank_q;
    end

    wr_ready_d      = ~cmpl_d & (state_d[wr_bank_d] != FULL);
    rd_bank_valid_d = (state_d[rd_bank_d] == FULL);
    rd_lines_d      = rd_bank_valid_d ? lines_d[rd_bank_d] : '0;
  end

  // Control and packing registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= {EMPTY, EMPTY};
      lines_q         <= '0;
      wr_bank_q       <= 1'b0;
      rd_bank_q       <= 1'b0;
      beat_q          <= '0;
      line_cnt_q      <= '0;
      pack_q          <= '0;
      lw_en_q         <= 1'b0;
      lw_bank_q       <= 1'b0;
      lw_addr_q       <= '0;
      lw_data_q       <= '0;
      cmpl_q          <= 1'b0;
      wr_ready_q      <= 1'b1;
      rd_bank_valid_q <= 1'b0;
      rd_lines_q      <= '0;
    end else begin
      state_q         <= state_d;
      lines_q         <= lines_d;
      wr_bank_q       <= wr_bank_d;
      rd_bank_q       <= rd_bank_d;
      beat_q          <= beat_d;
      line_cnt_q      <= line_cnt_d;
      pack_q          <= pack_d;
      lw_en_q         <= lw_en_d;
      lw_bank_q       <= lw_bank_d;
      lw_addr_q       <= lw_addr_d;
      lw_data_q       <= lw_data_d;
      cmpl_q          <= cmpl_d;
      wr_ready_q      <= wr_ready_d;
      rd_bank_valid_q <= rd_bank_valid_d;
      rd_lines_q      <= rd_lines_d;
    end
  end

  // Line memory write port; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (lw_en_q) mem_q[{lw_bank_q, lw_addr_q}] <= lw_data_q;
  end

  // Two-stage read pipeline; bank and range are captured at request time so
  // in-flight reads finish on the old bank after a release
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd1_v_q    <= 1'b0;
      rd1_oob_q  <= 1'b0;
      rd1_addr_q <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd1_v_q    <= rd_en & rd_bank_valid_q;
      rd1_oob_q  <= ({1'b0, rd_addr} >= rd_lines_q);
      rd1_addr_q <= {rd_bank_q, rd_addr};
      rd_valid_q <= rd1_v_q;
      if (rd1_v_q && !rd1_oob_q) rd_data_q <= mem_q[rd1_addr_q];
      else                       rd_data_q <= '0;
    end
  end

`ifdef WEIGHT_BUF_ACCESS_CHECK_EN
  localparam int unsigned WD_LIMIT = 4096;
  localparam int unsigned WD_W     = 13;

  logic [WD_W-1:0] wd_cnt_q;
  logic            err_q;
  logic            stall;

  assign stall = wr_valid & ~wr_ready_q;

  // Sticky access-error flag with write-stall watchdog
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (stall) begin
        if (wd_cnt_q != WD_W'(WD_LIMIT)) wd_cnt_q <= wd_cnt_q + 1'b1;
      end else begin
        wd_cnt_q <= '0;
      end
      if ((rd_en && (!rd_bank_valid_q || ({1'b0, rd_addr} >= rd_lines_q))) ||
          (rd_release && !rd_bank_valid_q) ||
          (stall && (wd_cnt_q == WD_W'(WD_LIMIT)))) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err_flag = err_q;
`else
  assign err_flag = 1'b0;
`endif

  assign wr_ready      = wr_ready_q;
  assign rd_bank_valid = rd_bank_valid_q;
  assign rd_lines      = rd_lines_q;
  assign rd_valid      = rd_valid_q;
  assign rd_data       = rd_data_q;

endmodule
